// File: rtl/bp_history_ctrl.sv
// Branch-prediction history controller: forms the PHT lookup index from the
// fetch PC and the speculative global history register (GHR). It tracks one
// in-flight branch from FETCH to DECODE, returns the resolved outcome to the
// PHT, repairs the GHR on a misprediction and keeps saturating statistics.
module bp_history_ctrl #(
  parameter int IWIDTH = 6,   // PHT index width
  parameter int HWIDTH = 4,   // GHR width, 1..IWIDTH (gselect needs < IWIDTH)
  parameter int MODE   = 1,   // 0 bimodal, 1 gshare, 2 gselect
  parameter int STATW  = 16   // statistics counter width
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              f_valid,
  input  logic              f_is_branch,
  input  logic [31:0]       f_pc,
  input  logic              f_off_neg,
  input  logic              pht_pred,
  input  logic              d_taken,
  output logic [IWIDTH-1:0] index,
  output logic              do_lookup,
  output logic              fallback,
  output logic              do_update,
  output logic              last_taken,
  output logic              mispredict,
  output logic [HWIDTH-1:0] ghr,
  output logic [STATW-1:0]  n_branch,
  output logic [STATW-1:0]  n_miss
);

  // In-flight branch record, captured in FETCH and consumed in DECODE.
  logic              d_vld;
  logic              d_pred;
  logic [HWIDTH-1:0] d_ghr;

  logic [IWIDTH-1:0] pc_bits;
  logic [IWIDTH-1:0] hist_ext;
  logic [HWIDTH:0]   ghr_shift;
  logic [HWIDTH-1:0] ghr_next;

  assign pc_bits  = f_pc[IWIDTH+1:2];
  assign hist_ext = IWIDTH'(ghr);

  // Index policy is fixed at elaboration; only the selected form is built.
  generate
    if (MODE == 1) begin : g_gshare
      assign index = pc_bits ^ hist_ext;
    end else if (MODE == 2) begin : g_gselect
      assign index = {pc_bits[IWIDTH-HWIDTH-1:0], ghr};
    end else begin : g_bimodal
      assign index = pc_bits;
    end
  endgenerate

  // PHT handshake and redirect. Every 1-bit output is held low during reset
  // so nothing downstream acts on a record that reset is about to discard.
  assign do_lookup  = !reset && en && f_valid && f_is_branch;
  assign fallback   = !reset && f_off_neg;
  assign last_taken = !reset && d_taken;
  assign do_update  = !reset && en && d_vld;
  assign mispredict = do_update && (d_taken != d_pred);

  // Next GHR: repair from the snapshot on a mispredict, otherwise shift in
  // the speculative prediction for a new branch, otherwise hold. Appending
  // the new bit and keeping the low HWIDTH bits also covers HWIDTH = 1.
  always_comb begin
    // NOTE: default assignment first so every path drives ghr_shift and no latch is inferred.
    ghr_shift = {1'b0, ghr};
    if (mispredict) begin
      ghr_shift = {d_ghr, d_taken};
    end else if (do_lookup) begin
      ghr_shift = {ghr, pht_pred};
    end
    ghr_next = ghr_shift[HWIDTH-1:0];
  end

  // History register and in-flight record; en low freezes everything.
  // NOTE: reset is asynchronous and active-high, so it sits in the sensitivity list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr    <= '0;
      d_vld  <= 1'b0;
      d_pred <= 1'b0;
      d_ghr  <= '0;
    end else if (en) begin
      // NOTE: non-blocking so d_ghr captures the pre-shift ghr of this same edge.
      ghr    <= ghr_next;
      d_vld  <= do_lookup && !mispredict;
      d_pred <= pht_pred;
      d_ghr  <= ghr;
    end
  end

  // Resolution statistics, saturating at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_branch <= '0;
      n_miss   <= '0;
    end else begin
      if (do_update && (n_branch != '1)) n_branch <= n_branch + 1'b1;
      if (mispredict && (n_miss != '1))  n_miss   <= n_miss + 1'b1;
    end
  end

  // PC bits outside the index field and the spare shift bit carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{f_pc[31:IWIDTH+2], f_pc[1:0], pc_bits, hist_ext, ghr_shift[HWIDTH]};

endmodule

// File: tb/tb_bp_history_ctrl.sv
// Self-checking bench for bp_history_ctrl (gshare, 6-bit index, 4-bit GHR,
// 8-bit statistics so saturation is reachable quickly). Expected values come
// from directed constants and from a behavioural model of the branch record.
module tb_bp_history_ctrl;

  localparam int IW = 6;
  localparam int HW = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, f_valid, f_is_branch, f_off_neg, pht_pred, d_taken;
  logic [31:0]   f_pc;
  logic [IW-1:0] index;
  logic          do_lookup, fallback, do_update, last_taken, mispredict;
  logic [HW-1:0] ghr;
  logic [SW-1:0] n_branch, n_miss;

  int n_cmp = 0;
  int n_bad = 0;

  bp_history_ctrl #(.IWIDTH(IW), .HWIDTH(HW), .MODE(1), .STATW(SW)) dut (
    .clk(clk), .reset(reset), .en(en), .f_valid(f_valid), .f_is_branch(f_is_branch),
    .f_pc(f_pc), .f_off_neg(f_off_neg), .pht_pred(pht_pred), .d_taken(d_taken),
    .index(index), .do_lookup(do_lookup), .fallback(fallback), .do_update(do_update),
    .last_taken(last_taken), .mispredict(mispredict), .ghr(ghr),
    .n_branch(n_branch), .n_miss(n_miss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] index;
    logic          do_lookup;
    logic          fallback;
    logic          do_update;
    logic          last_taken;
    logic          mispredict;
    logic [HW-1:0] ghr;
    logic [SW-1:0] n_branch;
    logic [SW-1:0] n_miss;
  } obs_t;

  obs_t obs;
  assign obs = {index, do_lookup, fallback, do_update, last_taken, mispredict, ghr, n_branch, n_miss};

  // Reference model: history as an integer, the pending branch as a small record.
  int m_ghr, m_pv, m_pp, m_pg, m_nb, m_nm;

  task automatic model_reset();
    m_ghr = 0; m_pv = 0; m_pp = 0; m_pg = 0; m_nb = 0; m_nm = 0;
  endtask

  function automatic obs_t model_out();
    obs_t e;
    bit look, upd;
    look = !reset && en && f_valid && f_is_branch;
    upd  = !reset && en && (m_pv != 0);
    e.index      = IW'((f_pc >> 2) ^ m_ghr);
    e.do_lookup  = look;
    e.fallback   = !reset && f_off_neg;
    e.do_update  = upd;
    e.last_taken = !reset && d_taken;
    e.mispredict = upd && (int'(d_taken) != m_pp);
    e.ghr        = HW'(m_ghr);
    e.n_branch   = SW'(m_nb);
    e.n_miss     = SW'(m_nm);
    return e;
  endfunction

  // Advance the model by one enabled edge, then let the DUT take the same edge.
  task automatic advance();
    obs_t e;
    int   old_ghr;
    e = model_out();
    if (!reset && en) begin
      old_ghr = m_ghr;
      if (e.mispredict)     m_ghr = ((m_pg << 1) | int'(d_taken)) % (1 << HW);
      else if (e.do_lookup) m_ghr = ((m_ghr << 1) | int'(pht_pred)) % (1 << HW);
      m_pv = (e.do_lookup && !e.mispredict) ? 1 : 0;
      m_pp = int'(pht_pred);
      m_pg = old_ghr;
      if (e.do_update)  m_nb = (m_nb + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_nb + 1;
      if (e.mispredict) m_nm = (m_nm + 1 > (1 << SW) - 1) ? (1 << SW) - 1 : m_nm + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit e_, v, b, input logic [31:0] pc, input bit neg, pp, dt);
    en = e_; f_valid = v; f_is_branch = b; f_pc = pc; f_off_neg = neg; pht_pred = pp; d_taken = dt;
    #3;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({do_lookup, fallback, do_update, last_taken, mispredict, ghr, n_branch, n_miss} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %p want all-zero controls/state", obs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_correct_predict();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({index, do_lookup, fallback, do_update} !== {6'h10, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL lookup_index: got idx=%h lk=%b fb=%b upd=%b want idx=10 lk=1 fb=1 upd=0", index, do_lookup, fallback, do_update);
    end
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({do_update, last_taken, mispredict, ghr} !== {1'b1, 1'b1, 1'b0, 4'b0001}) begin
      n_bad++;
      $display("FAIL correct_resolve: got upd=%b lt=%b mis=%b ghr=%b want 1 1 0 0001", do_update, last_taken, mispredict, ghr);
    end
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({do_update, ghr, n_branch, n_miss} !== {1'b0, 4'b0001, 8'd1, 8'd0}) begin
      n_bad++;
      $display("FAIL after_correct: got upd=%b ghr=%b nb=%0d nm=%0d want 0 0001 1 0", do_update, ghr, n_branch, n_miss);
    end
    advance();
  endtask

  task automatic test_mispredict();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    advance();
    drive(1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({mispredict, do_update, last_taken, ghr} !== {1'b1, 1'b1, 1'b0, 4'b0001}) begin
      n_bad++;
      $display("FAIL mispredict_flag: got mis=%b upd=%b lt=%b ghr=%b want 1 1 0 0001", mispredict, do_update, last_taken, ghr);
    end
    advance();
    drive(1'b1, 1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({do_update, mispredict, ghr, n_branch, n_miss} !== {1'b0, 1'b0, 4'b0000, 8'd1, 8'd1}) begin
      n_bad++;
      $display("FAIL ghr_repair: got upd=%b mis=%b ghr=%b nb=%0d nm=%0d want 0 0 0000 1 1", do_update, mispredict, ghr, n_branch, n_miss);
    end
    advance();
  endtask

  task automatic test_freeze();
    obs_t e;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 1'($urandom));
      e = model_out();
      n_cmp++;
      if (obs !== e || {do_update, do_lookup, mispredict, ghr, n_branch} !== {1'b0, 1'b0, 1'b0, 4'b0001, 8'd0}) begin
        n_bad++;
        $display("FAIL freeze[%0d]: got %p want %p", i, obs, e);
      end
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({do_update, mispredict, last_taken} !== {1'b1, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL freeze_resume: got upd=%b mis=%b lt=%b want 1 0 1", do_update, mispredict, last_taken);
    end
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (n_branch !== 8'd1) begin
      n_bad++;
      $display("FAIL freeze_count: got nb=%0d want 1", n_branch);
    end
    advance();
  endtask

  task automatic test_saturation();
    obs_t e;
    do_reset();
    for (int i = 0; i < (1 << SW) + 6; i++) begin
      drive(1'b1, 1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
      e = model_out();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL sat_branch[%0d]: got %p want %p", i, obs, e);
      end
      advance();
    end
    n_cmp++;
    if (n_branch !== 8'hFF) begin
      n_bad++;
      $display("FAIL n_branch_sat: got %0d want 255", n_branch);
    end
    do_reset();
    for (int i = 0; i < 2 * (1 << SW) + 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, $urandom & 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
      e = model_out();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL sat_miss[%0d]: got %p want %p", i, obs, e);
      end
      advance();
    end
    n_cmp++;
    if (n_miss !== 8'hFF) begin
      n_bad++;
      $display("FAIL n_miss_sat: got %0d want 255", n_miss);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    advance();
    drive(1'b1, 1'b1, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({do_lookup, fallback, do_update, last_taken, mispredict, ghr, n_branch, n_miss} !== '0) begin
      n_bad++;
      $display("FAIL reset_midflight: got %p want all-zero controls/state", obs);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({do_update, mispredict, ghr} !== {1'b0, 1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL stale_record: got upd=%b mis=%b ghr=%b want 0 0 0000", do_update, mispredict, ghr);
    end
    advance();
  endtask

  task automatic test_random();
    obs_t e;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 1'($urandom));
      e = model_out();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL random[%0d]: got %p want %p", i, obs, e);
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; f_valid = 1'b0; f_is_branch = 1'b0; f_pc = '0;
    f_off_neg = 1'b0; pht_pred = 1'b0; d_taken = 1'b0;
    model_reset();
    test_reset();
    test_correct_predict();
    test_mispredict();
    test_freeze();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
